// File: rtl/vscodec_ctrl_seq.sv
// vscodec_ctrl_seq: command sequencer driving the codec control lines through an Avalon PIO.
// The PIO carries the codec's active-low xRESET (bit0), xCS (bit1) and xDCS (bit2); the
// data register sits at addr 0, the bit-set register at addr 4 and the bit-clear register
// at addr 5.
//
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   cmd_valid/cmd_op       command request; op 00 HW_RESET, 01 SEL_SCI, 10 SEL_SDI, 11 DESELECT
//   cmd_ready              high only when idle (command accepted on cmd_valid && cmd_ready)
//   busy                   command in progress
//   done / err             one-cycle completion / DREQ-timeout pulses
//   dreq                   codec DREQ (asynchronous, synchronized internally)
//   pio_*                  Avalon write master towards the codec PIO
module vscodec_ctrl_seq #(
  parameter int unsigned RESET_LOW_CYCLES = 1000,
  parameter int unsigned DREQ_TIMEOUT     = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  output logic        cmd_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        dreq,
  output logic [2:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata
);

  localparam logic [1:0] OpHwReset  = 2'b00;
  localparam logic [1:0] OpSelSci   = 2'b01;
  localparam logic [1:0] OpDeselect = 2'b11;

  // One counter serves both the reset hold and the DREQ wait, so size it for the larger.
  localparam int unsigned CntMax = (RESET_LOW_CYCLES > DREQ_TIMEOUT) ?
                                   RESET_LOW_CYCLES : DREQ_TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 2);

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StHold,
    StWaitDreq,
    StFin
  } state_e;

  state_e          state_q;
  logic [1:0]      op_q;
  logic            rel_q;       // current HW_RESET write is the release write
  logic [CntW-1:0] cnt_q;
  logic            done_q;
  logic            err_q;
  logic            pio_cs_q;
  logic [2:0]      pio_addr_q;
  logic [2:0]      pio_data_q;
  logic            dreq_s1_q;
  logic            dreq_s2_q;

  logic [31:0]     cnt_ext;
  logic [CntW-1:0] cnt_inc;

  assign cnt_ext = 32'(cnt_q);
  // Saturating increment: the counter holds at all-ones rather than wrapping.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // Two-flop synchronizer; only dreq_s2_q is used by the sequencer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dreq_s1_q <= 1'b0;
      dreq_s2_q <= 1'b0;
    end else begin
      dreq_s1_q <= dreq;
      dreq_s2_q <= dreq_s1_q;
    end
  end

  // Sequencer with registered outputs. The pulse/write registers default to idle every cycle
  // and are set only on the transition into the cycle that must show them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      op_q       <= 2'b00;
      rel_q      <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      pio_cs_q   <= 1'b0;
      pio_addr_q <= 3'd0;
      pio_data_q <= 3'd0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      pio_cs_q   <= 1'b0;
      pio_addr_q <= 3'd0;
      pio_data_q <= 3'd0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            rel_q <= 1'b0;
            cnt_q <= '0;
            if (cmd_op == OpHwReset) begin
              // Assert xRESET via the clear register.
              state_q    <= StWr;
              pio_cs_q   <= 1'b1;
              pio_addr_q <= 3'd5;
              pio_data_q <= 3'b001;
            end else if (cmd_op == OpDeselect) begin
              // Raise xCS and xDCS via the set register.
              state_q    <= StWr;
              pio_cs_q   <= 1'b1;
              pio_addr_q <= 3'd4;
              pio_data_q <= 3'b110;
            end else begin
              state_q <= StWaitDreq;
            end
          end
        end
        StWr: begin
          if (op_q == OpHwReset && !rel_q) begin
            cnt_q <= '0;
            if (RESET_LOW_CYCLES == 0) begin
              state_q    <= StWr;
              rel_q      <= 1'b1;
              pio_cs_q   <= 1'b1;
              pio_addr_q <= 3'd4;
              pio_data_q <= 3'b111;
            end else begin
              state_q <= StHold;
            end
          end else if (op_q == OpHwReset) begin
            state_q <= StWaitDreq;
            cnt_q   <= '0;
          end else begin
            state_q <= StFin;
            done_q  <= 1'b1;
          end
        end
        StHold: begin
          if (cnt_ext + 32'd1 >= RESET_LOW_CYCLES) begin
            // Release reset and leave both selects deasserted.
            state_q    <= StWr;
            rel_q      <= 1'b1;
            pio_cs_q   <= 1'b1;
            pio_addr_q <= 3'd4;
            pio_data_q <= 3'b111;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StWaitDreq: begin
          // DREQ is tested before the timeout so a ready codec wins even on the last cycle.
          if (dreq_s2_q) begin
            if (op_q == OpHwReset) begin
              state_q <= StFin;
              done_q  <= 1'b1;
            end else begin
              // Full data write: exactly one of xCS/xDCS low.
              state_q    <= StWr;
              pio_cs_q   <= 1'b1;
              pio_addr_q <= 3'd0;
              pio_data_q <= (op_q == OpSelSci) ? 3'b101 : 3'b011;
            end
          end else if (cnt_ext + 32'd1 >= DREQ_TIMEOUT) begin
            state_q <= StFin;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign cmd_ready      = (state_q == StIdle);
  assign busy           = (state_q != StIdle);
  assign done           = done_q;
  assign err            = err_q;
  assign pio_chipselect = pio_cs_q;
  assign pio_write_n    = ~pio_cs_q;
  assign pio_address    = pio_addr_q;
  assign pio_writedata  = {29'd0, pio_data_q};

endmodule

// File: doc/vscodec_ctrl_seq.md
VSCODEC_CTRL_SEQ -- requirements
Module: vscodec_ctrl_seq

Interface
REQ-001 SHALL have parameter RESET_LOW_CYCLES, default 1000: number of cycles xRESET is held low.
REQ-002 SHALL have parameter DREQ_TIMEOUT, default 65535: maximum number of cycles spent waiting for DREQ.
REQ-003 SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock for all logic.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_op  in  2  command: 00 HW_RESET, 01 SEL_SCI, 10 SEL_SDI, 11 DESELECT.
- cmd_ready  out  1  controller can accept a command.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse, command completed.
- err  out  1  one-cycle pulse, DREQ timeout.
- dreq  in  1  codec DREQ, asynchronous.
- pio_address  out  3  Avalon address to the codec PIO.
- pio_chipselect  out  1  Avalon chipselect.
- pio_write_n  out  1  Avalon write, active low.
- pio_writedata  out  32  Avalon write data.
REQ-004 Codec PIO bit map SHALL be: bit0 = xRESET, bit1 = xCS, bit2 = xDCS, all active low. PIO registers: addr 0 = data, addr 4 = set bits, addr 5 = clear bits.

Function
REQ-005 States SHALL be IDLE, WR, HOLD, WAIT_DREQ and FIN.
REQ-006 cmd_ready SHALL be 1 only in IDLE; a command is accepted on the cycle cmd_valid && cmd_ready; cmd_op is captured on acceptance.
REQ-007 busy SHALL be 1 in every state except IDLE.
REQ-008 Each PIO write SHALL last exactly one cycle: pio_chipselect=1, pio_write_n=0.
REQ-009 Outside a write cycle: pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0.
REQ-010 pio_writedata[31:3] SHALL always be 0.
REQ-011 HW_RESET sequence:
- write addr 5, data 0x1, on cycle T+1 (T = acceptance cycle);
- HOLD exactly RESET_LOW_CYCLES cycles with no write;
- write addr 4, data 0x7 (release reset, deselect both);
- WAIT_DREQ.
REQ-012 SEL_SCI sequence: WAIT_DREQ, then write addr 0, data 0x5 (xCS low, xDCS high).
REQ-013 SEL_SDI sequence: WAIT_DREQ, then write addr 0, data 0x3 (xDCS low, xCS high).
REQ-014 DESELECT sequence: write addr 4, data 0x6 on T+1; no DREQ wait.
REQ-015 xCS and xDCS SHALL never be driven low together by any write this block issues.
REQ-016 dreq SHALL pass through a 2-flop synchronizer; only the synchronized value is used.
REQ-017 WAIT_DREQ rules:
- the wait counter clears on entry;
- synchronized dreq=1 ends the wait successfully, including on the entry cycle;
- the counter reaching DREQ_TIMEOUT with dreq still 0 is a timeout.
REQ-018 On timeout: no further PIO write for that command; err pulses for one cycle; return to IDLE.
REQ-019 Command completion:
- done pulses on the cycle after the command's last write, or after WAIT_DREQ succeeds for HW_RESET;
- each accepted command produces exactly one done or one err, never both.
REQ-020 Back-to-back commands: the FIN/err cycle returns to IDLE; a new command is accepted no earlier than the cycle after done or err.
REQ-021 cmd_valid while busy SHALL be ignored; cmd_op changes after acceptance SHALL have no effect.
REQ-022 Counters SHALL saturate and never wrap; RESET_LOW_CYCLES=0 gives release write on the cycle directly after the clear write.

Reset
REQ-023 reset_n=0 at a rising clk edge SHALL force, at any point including mid-sequence:
- state IDLE, counters 0, synchronizer 0;
- cmd_ready=1, busy=0, done=0, err=0;
- pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0.
REQ-024 No PIO write SHALL be issued on the cycle reset is released.

Verification (RESET_LOW_CYCLES=4, DREQ_TIMEOUT=8)
REQ-025 HW_RESET with dreq tied 1 -> write (5, 0x1) at T+1, no writes T+2..T+5, write (4, 0x7) at T+6, done at T+9 or earlier after 2-cycle synchronizer delay, busy low next cycle.
REQ-026 SEL_SCI with dreq=0 rising at T+3 -> no write until synchronized dreq=1, then single write (0, 0x5), done next cycle.
REQ-027 SEL_SDI with dreq held 0 -> no PIO write, err pulse exactly once after 8 wait cycles, done never asserted, cmd_ready=1 afterwards.
REQ-028 DESELECT -> write (4, 0x6) at T+1, done at T+2; cmd_valid held high gives next acceptance no earlier than T+3.
REQ-029 reset_n=0 during HOLD of HW_RESET -> next cycle all outputs at reset values, no release write issued; new DESELECT after reset completes normally.
REQ-030 Scoreboard over all scenarios -> no write with data having bit1=0 and bit2=0 at addr 0; every accepted command yields exactly one done or err.
